// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with bit-serial shifts and a flag register
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_err,
  output logic [WIDTH-1:0] flags
);
  localparam int M = WIDTH - 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  localparam logic [4:0] ZERO = 5'd0, SIGN = 5'd1, PASSFLAG = 5'd2, LOADFLAG = 5'd3,
    INV = 5'd4, OR = 5'd5, AND = 5'd6, XOR = 5'd7, ADD = 5'd8, SUB = 5'd9,
    SHL = 5'd10, SHR = 5'd11, SAR = 5'd12;
  logic [1:0] state;
  logic [SHW-1:0] cnt;
  logic [4:0] op;
  logic [WIDTH-1:0] acc, r, nf, sh_nxt;
  logic [WIDTH:0] sum, dif;
  logic is_sh, err, sh_c;
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    is_sh = cmd inside {SHL, SHR, SAR};
    r = '0;
    nf = flags;
    err = 1'b0;
    case (cmd)
      ZERO: r = '0;
      SIGN: begin
        r = {WIDTH{b[M]}};
        nf[9] = b[0];
        nf[11] = ~b[0];
      end
      PASSFLAG: r = flags;
      LOADFLAG: begin
        r = a;
        nf = a;
      end
      INV: r = ~a;
      OR: r = a | b;
      AND: r = a & b;
      XOR: r = a ^ b;
      ADD: begin
        r = sum[M:0];
        nf[8] = sum[WIDTH];
        nf[10] = (a[M] == b[M]) && (r[M] != a[M]);
      end
      SUB: begin
        r = dif[M:0];
        nf[8] = dif[WIDTH];
        nf[10] = (a[M] != b[M]) && (r[M] != a[M]);
      end
      SHL, SHR, SAR: begin
        r = a;
        nf[8] = 1'b0;
        nf[10] = 1'b0;
      end
      default: err = 1'b1;
    endcase
    if (is_sh || cmd inside {ZERO, INV, OR, AND, XOR, ADD, SUB}) begin
      nf[9] = r[M];
      nf[11] = r == '0;
    end
    if (cmd inside {INV, OR, AND, XOR}) begin
      nf[8] = 1'b0;
      nf[10] = 1'b0;
    end
    sh_nxt = op == SHL ? acc << 1 : op == SHR ? acc >> 1 : {acc[M], acc[M:1]};
    sh_c = op == SHL ? acc[M] : acc[0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      acc <= '0;
      out <= '0;
      out_err <= 1'b0;
      flags <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= cmd;
          acc <= a;
          out_err <= err;
          if (is_sh && b[SHW-1:0] != '0) begin
            state <= SHIFT;
            cnt <= b[SHW-1:0];
          end else begin
            state <= DONE;
            out <= r;
            flags <= nf;
          end
        end
        SHIFT: begin
          acc <= sh_nxt;
          cnt <= cnt - SHW'(1);
          // the final single-bit step lands the result and its flags together
          if (cnt == SHW'(1)) begin
            state <= DONE;
            out <= sh_nxt;
            flags <= {flags[M:12], sh_nxt == '0, 1'b0, sh_nxt[M], sh_c, flags[7:0]};
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a latency/result model
module tb_alu_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [4:0] cmd = 0;
  logic [63:0] a = 0, b = 0;
  logic in_ready, out_valid, out_err;
  logic [63:0] out, flags;
  int n_chk = 0, n_pass = 0;

  alu_seq #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_err(out_err), .flags(flags));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // result/flags/latency from the instruction-set rules, shifts done in one step
  function automatic void model(input logic [4:0] c, input logic [63:0] x, y, f,
      output logic [63:0] r, output logic e, output logic [63:0] nf, output int lat);
    logic [64:0] s;
    logic [65:0] t;
    int n;
    logic nz;
    r = 0; e = 0; nf = f; lat = 0; nz = 0; n = int'(y[5:0]);
    case (c)
      0: nz = 1;
      1: begin r = y[63] ? '1 : '0; nf[9] = y[0]; nf[11] = !y[0]; end
      2: r = f;
      3: begin r = x; nf = x; end
      4: begin r = ~x; nz = 1; nf[8] = 0; nf[10] = 0; end
      5: begin r = x | y; nz = 1; nf[8] = 0; nf[10] = 0; end
      6: begin r = x & y; nz = 1; nf[8] = 0; nf[10] = 0; end
      7: begin r = x ^ y; nz = 1; nf[8] = 0; nf[10] = 0; end
      8: begin
        s = {1'b0, x} + {1'b0, y}; r = s[63:0]; nf[8] = s[64];
        t = {{2{x[63]}}, x} + {{2{y[63]}}, y}; nf[10] = t[64] != t[63]; nz = 1;
      end
      9: begin
        r = x - y; nf[8] = x < y;
        t = {{2{x[63]}}, x} - {{2{y[63]}}, y}; nf[10] = t[64] != t[63]; nz = 1;
      end
      10: begin r = x << n; nf[8] = n > 0 ? x[64-n] : 1'b0; nf[10] = 0; nz = 1; lat = n; end
      11: begin r = x >> n; nf[8] = n > 0 ? x[n-1] : 1'b0; nf[10] = 0; nz = 1; lat = n; end
      12: begin r = 64'($signed(x) >>> n); nf[8] = n > 0 ? x[n-1] : 1'b0; nf[10] = 0; nz = 1; lat = n; end
      default: e = 1;
    endcase
    if (nz) begin nf[9] = r[63]; nf[11] = r == 0; end
  endfunction

  logic m_valid = 0, m_busy = 0, m_err = 0, p_err;
  logic [63:0] m_out = 0, m_flags = 0, p_out, p_flags;
  int m_cnt = 0, p_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_busy = 0; m_cnt = 0; m_flags = 0; m_out = 0; m_err = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin m_busy = 0; m_valid = 1; m_out = p_out; m_flags = p_flags; end
    end else if (in_valid) begin
      model(cmd, a, b, m_flags, p_out, p_err, p_flags, p_lat);
      m_err = p_err;
      if (p_lat == 0) begin m_valid = 1; m_out = p_out; m_flags = p_flags; end
      else begin m_busy = 1; m_cnt = p_lat; end
    end
  end

  always @(posedge clk) begin
    #3;
    chk("in_ready", 64'(in_ready), 64'(!rst && !m_valid && !m_busy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("flags", flags, m_flags);
    if (m_valid) begin
      chk("out", out, m_out);
      chk("out_err", 64'(out_err), 64'(m_err));
    end
  end

  task automatic send(input logic [4:0] c, input logic [63:0] x, y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1; cmd = c; a = x; b = y;
    @(negedge clk);
    in_valid = 0; cmd = 5'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
  endtask

  task automatic wait_out(input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic take;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_flags", flags, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    send(5'd8, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    wait_out(1);
    chk("add_out", out, 64'h8000_0000_0000_0000);
    chk("add_flags", flags, 64'h600);
    take;
    send(5'd9, 64'd5, 64'd5);
    wait_out(1);
    chk("sub0_out", out, 64'd0);
    chk("sub0_flags", flags, 64'h800);
    take;
    send(5'd9, 64'd0, 64'd1);
    wait_out(1);
    chk("subm1_out", out, '1);
    chk("subm1_flags", flags, 64'h300);
    take;
    send(5'd11, 64'h8000_0000_0000_0001, 64'd3);
    wait_out(4);
    chk("shr_out", out, 64'h1000_0000_0000_0000);
    chk("shr_flags", flags, 64'h000);
    take;
    send(5'd12, 64'h8000_0000_0000_0001, 64'd3);
    wait_out(4);
    chk("sar_out", out, 64'hF000_0000_0000_0000);
    chk("sar_flags", flags, 64'h200);
    take;
    send(5'd3, 64'h0A00, 64'd0);
    wait_out(1);
    chk("load_flags", flags, 64'h0A00);
    take;
    send(5'd2, 64'd7, 64'd9);
    wait_out(1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out", out, 64'h0A00);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1; cmd = 5'd0;
      @(negedge clk);
    end
    in_valid = 0;
    take;
    send(5'd31, 64'd3, 64'd4);
    wait_out(1);
    chk("undef_out", out, 64'd0);
    chk("undef_err", 64'(out_err), 64'd1);
    chk("undef_flags", flags, 64'h0A00);
    take;
    send(5'd1, 64'd0, 64'h8000_0000_0000_0000);
    wait_out(1);
    chk("sign_out", out, '1);
    chk("sign_flags", flags, 64'h800);
    take;
    send(5'd10, 64'd5, 64'd64);
    wait_out(1);
    chk("shl0_out", out, 64'd5);
    chk("shl0_flags", flags, 64'h000);
    take;
    send(5'd10, 64'hFFFF, 64'd40);
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_flags", flags, 64'd0);
    rst = 0;
    #1 chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("abort_no_result", 64'(out_valid), 64'd0);
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      cmd = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 13));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    repeat (80) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
